audio_synth_mixer: RTL
======================

Name: audio_synth_mixer

Overview:
- Multi-voice successor to the two-channel speaker path.
- N_VOICES independent square-wave tone generators, each with its own divider, 4-bit volume and left/right pan enables.
- Voices are summed per channel with saturation, latched once per audio frame, and serialised onto the Pmod I2S pins (mclk/lrclk/sclk/sdin).
- Sits between the music/keyboard control logic and the board audio pins.

Parameters:
- N_VOICES, 4, number of tone generators (1..8)
- DIV_W, 22, width of each note divider
- VOL_W, 4, width of each volume field
- AMP_STEP, 512, amplitude per volume LSB (vol 15 -> 7680)

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- note_div  in  N_VOICES*DIV_W  per-voice half-period in clk cycles; voice i at [i*DIV_W +: DIV_W]
- volume  in  N_VOICES*VOL_W  per-voice volume; voice i at [i*VOL_W +: VOL_W]
- pan_l  in  N_VOICES  voice i contributes to left channel
- pan_r  in  N_VOICES  voice i contributes to right channel
- mute  in  1  master mute, sampled at frame capture
- audio_mclk  out  1  clk/4
- audio_lrclk  out  1  clk/512; low = left half-frame
- audio_sclk  out  1  clk/16
- audio_sdin  out  1  serial sample data, MSB first
- frame_tick  out  1  one-cycle pulse on the capture cycle

Behaviour:
- Reset (rst=0, async):
  - All counters, phases and latched samples cleared.
  - All outputs 0.
- Tone voice i:
  - Counter cnt_i increments every clk.
  - When cnt_i >= div_i-1: cnt_i <- 0 and phase_i toggles.
  - If div_i is lowered below the current count, the wrap occurs on the next cycle.
  - If div_i is 0 or 1: cnt_i held at 0, phase_i held at 0, voice output 0 (silent).
- Voice sample, 16-bit signed:
  - amp = vol_i*AMP_STEP.
  - Sample is +amp when phase_i=1, -amp when phase_i=0; 0 when silent or vol_i=0.
- Mix (combinational):
  - L = sum of voice samples with pan_l[i]=1; R = sum of voice samples with pan_r[i]=1.
  - Accumulate in 16+ceil(log2(N_VOICES)) bits signed.
  - Saturate to [-32768, 32767]; no wrap-around permitted.
- Frame timing:
  - 9-bit free-running frame counter fc, 0..511, wraps to 0.
  - Derived outputs: mclk=fc[1], sclk=fc[3], lrclk=fc[8].
- Capture:
  - On the cycle fc==511: lat_L <- (mute ? 0 : L) and lat_R <- (mute ? 0 : R).
  - frame_tick=1 on that same cycle only.
- Serialisation (left-justified):
  - sdin = (fc[8] ? lat_R : lat_L)[15 - fc[7:4]].
  - sdin changes only when fc[3:0] wraps 15->0 (sclk falling edge) and is stable at the sclk rising edge (fc[3:0]=8).
  - All four audio outputs are registered and aligned to the current fc value; each frame uses exactly the samples captured at its start.
- Mid-frame input changes (note_div/volume/pan/mute) never alter the frame being shifted out; they take effect at the next capture.
- Reset mid-frame aborts the frame immediately: outputs 0, fc=0. After release the first frame shifts zeros.
- Latency:
  - Tone edge to captured sample: up to 512 cycles.
  - Capture to first sdin bit of left: 1 cycle.

Decomposition:
- Shared package:
  - DIV_W, SAMPLE_W=16, SAT_MAX=32767, SAT_MIN=-32768
  - FRAME_LEN=512, SCLK_DIV=16, MCLK_DIV=4
  - Default AMP_STEP
- Sub-module tone_voice: counter, phase and signed sample output. Instantiated N_VOICES times via generate.
- Mixer, saturation and serialiser stay in the top.

Test Plan:
- Reset/clocks: hold rst=0 for 10 cycles -> all outputs 0. After release, check periods: mclk 4, sclk 16, lrclk 512 cycles; frame_tick once every 512 cycles.
- Single voice: voice0 div=4, vol=15, pan_l=pan_r=1, others div=0 -> phase toggles every 4 cycles. Each frame's lat_L equals lat_R, and each equals 0x1E00 or 0xE200. sdin shifts MSB first, left half while lrclk=0.
- Saturation: AMP_STEP=2048, all 4 voices div=100, vol=15, both pans, released together from reset -> both channels read 0x7FFF when phases are high and 0x8000 when low; never a wrapped value.
- Silence/pan: voice0 div=1 vol=15; voice1 div=50 vol=2 pan_l only; voice2 div=50 vol=3 pan_r only -> L = ±1024, R = ±1536, voice0 contributes 0.
- Mute: assert mute at fc=300 -> the current frame completes with the old sample; the next frame shifts 0x0000 on both halves.
- Mid-frame changes: change voice0 volume 15->1 at fc=100 -> sdin for the current frame unchanged; the new value is seen after the next frame_tick. Pulse rst at fc=200 -> sdin/lrclk/sclk/mclk drop to 0 immediately.

Source files
------------

// File: rtl/audio_synth_mixer_pkg.sv
// Shared constants and the saturation helper for the multi-voice audio mixer.
package audio_synth_mixer_pkg;

  localparam int DIV_W     = 22;
  localparam int SAMPLE_W  = 16;
  localparam int SAT_MAX   = 32767;
  localparam int SAT_MIN   = -32768;
  localparam int FRAME_LEN = 512;
  localparam int SCLK_DIV  = 16;
  localparam int MCLK_DIV  = 4;
  localparam int AMP_STEP  = 512;

  // Clamp a wide signed value into the 16-bit sample range instead of wrapping.
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [31:0] v);
    if (v > SAT_MAX) begin
      sat16 = 16'sh7fff;
    end else if (v < SAT_MIN) begin
      sat16 = 16'sh8000;
    end else begin
      sat16 = v[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/audio_synth_mixer_tone_voice.sv
// One square-wave tone generator: half-period divider, phase flip-flop and signed sample.
module audio_synth_mixer_tone_voice #(
  parameter int DIV_W    = audio_synth_mixer_pkg::DIV_W,
  parameter int VOL_W    = 4,
  parameter int AMP_STEP = audio_synth_mixer_pkg::AMP_STEP
) (
  input  logic                                              clk,
  input  logic                                              rst,
  input  logic [DIV_W-1:0]                                  div,
  input  logic [VOL_W-1:0]                                  vol,
  output logic signed [audio_synth_mixer_pkg::SAMPLE_W-1:0] sample
);
  import audio_synth_mixer_pkg::*;

  logic [DIV_W-1:0]   cnt;
  logic               phase;
  logic               silent;
  logic signed [31:0] amp;

  assign silent = (div <= DIV_W'(1));

  // Count clk cycles and flip the phase each time the half-period elapses; a divider of 0 or 1 parks the voice.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (silent) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (cnt >= div - DIV_W'(1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

  // Turn the phase into a +/- amplitude sample scaled by the volume field.
  always_comb begin
    amp = $signed(32'(vol)) * AMP_STEP;
    if (silent || (vol == '0)) begin
      sample = '0;
    end else if (phase) begin
      sample = sat16(amp);
    end else begin
      sample = sat16(-amp);
    end
  end

endmodule

// File: rtl/audio_synth_mixer.sv
// Multi-voice tone mixer: sums voices per channel with saturation, latches once per frame, shifts out I2S.
module audio_synth_mixer #(
  parameter int N_VOICES = 4,
  parameter int DIV_W    = audio_synth_mixer_pkg::DIV_W,
  parameter int VOL_W    = 4,
  parameter int AMP_STEP = audio_synth_mixer_pkg::AMP_STEP
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_VOICES*DIV_W-1:0] note_div,
  input  logic [N_VOICES*VOL_W-1:0] volume,
  input  logic [N_VOICES-1:0]       pan_l,
  input  logic [N_VOICES-1:0]       pan_r,
  input  logic                      mute,
  output logic                      audio_mclk,
  output logic                      audio_lrclk,
  output logic                      audio_sclk,
  output logic                      audio_sdin,
  output logic                      frame_tick
);
  import audio_synth_mixer_pkg::*;

  localparam int ACC_W   = SAMPLE_W + $clog2(N_VOICES);
  localparam int FC_W    = $clog2(FRAME_LEN);
  localparam int SCLK_SH = $clog2(SCLK_DIV);
  localparam int MCLK_SH = $clog2(MCLK_DIV);

  logic signed [SAMPLE_W-1:0] voice_sample [N_VOICES];
  logic signed [ACC_W-1:0]    acc_l, acc_r;
  logic signed [SAMPLE_W-1:0] cap_l, cap_r;
  logic signed [SAMPLE_W-1:0] lat_l, lat_r;
  logic [FC_W-1:0]            fc, fc_next;
  logic                       capture;
  logic [SAMPLE_W-1:0]        word;
  logic [3:0]                 bit_idx;
  logic                       sdin_next;

  generate
    for (genvar i = 0; i < N_VOICES; i++) begin : g_voice
      audio_synth_mixer_tone_voice #(
        .DIV_W   (DIV_W),
        .VOL_W   (VOL_W),
        .AMP_STEP(AMP_STEP)
      ) u_voice (
        .clk   (clk),
        .rst   (rst),
        .div   (note_div[i*DIV_W +: DIV_W]),
        .vol   (volume[i*VOL_W +: VOL_W]),
        .sample(voice_sample[i])
      );
    end
  endgenerate

  // Sum the panned voices in a widened accumulator, then clamp and apply the master mute.
  always_comb begin
    acc_l = '0;
    acc_r = '0;
    for (int i = 0; i < N_VOICES; i++) begin
      if (pan_l[i]) acc_l = acc_l + ACC_W'(voice_sample[i]);
      if (pan_r[i]) acc_r = acc_r + ACC_W'(voice_sample[i]);
    end
    cap_l = mute ? '0 : sat16(32'(acc_l));
    cap_r = mute ? '0 : sat16(32'(acc_r));
  end

  // Pick the next serial bit from the frame's latched words; on capture the fresh left word goes out directly.
  always_comb begin
    fc_next = fc + FC_W'(1);
    capture = (fc == FC_W'(FRAME_LEN - 1));
    bit_idx = 4'(SAMPLE_W - 1) - fc_next[FC_W-2:SCLK_SH];
    if (capture) begin
      word = cap_l;
    end else if (fc_next[FC_W-1]) begin
      word = lat_r;
    end else begin
      word = lat_l;
    end
    sdin_next = word[bit_idx];
  end

  // Frame counter, per-frame sample latch and registered I2S outputs aligned to the current count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fc          <= '0;
      lat_l       <= '0;
      lat_r       <= '0;
      audio_mclk  <= 1'b0;
      audio_lrclk <= 1'b0;
      audio_sclk  <= 1'b0;
      audio_sdin  <= 1'b0;
      frame_tick  <= 1'b0;
    end else begin
      fc          <= fc_next;
      audio_mclk  <= fc_next[MCLK_SH-1];
      audio_sclk  <= fc_next[SCLK_SH-1];
      audio_lrclk <= fc_next[FC_W-1];
      audio_sdin  <= sdin_next;
      frame_tick  <= (fc_next == FC_W'(FRAME_LEN - 1));
      if (capture) begin
        lat_l <= cap_l;
        lat_r <= cap_r;
      end
    end
  end

endmodule
